raster_bbox_scanner: RTL and testbench
======================================

// Module: raster_bbox_scanner
// PURPOSE
//  Upstream feeder for the per-edge test pipeline. Accepts one triangle (3 signed vertices)
//  per command, computes its screen-clamped bounding box and streams every pixel in it in
//  row-major order over a valid/ready handshake. Triangle vertices are held stable on output
//  ports for the whole scan so downstream edge stages read V1/V2 directly.
// PARAMETERS
//  COORD_W  11   coordinate width (signed vertices, unsigned pixel outputs)
//  H_RES    640  screen width in pixels; x range 0..H_RES-1
//  V_RES    480  screen height in pixels; y range 0..V_RES-1
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset
//  tri_valid    in   1        triangle command valid
//  tri_ready    out  1        scanner idle, command accepted on tri_valid&tri_ready
//  v0_x..v2_y   in   6xCOORD_W signed vertex coordinates (v0_x,v0_y,v1_x,v1_y,v2_x,v2_y)
//  vtx_x_out    out  3xCOORD_W registered v0..v2 x, held from accept until next accept
//  vtx_y_out    out  3xCOORD_W registered v0..v2 y, same hold rule
//  pix_valid    out  1        pixel_x/pixel_y valid
//  pix_ready    in   1        downstream accepts pixel
//  pixel_x      out  COORD_W  unsigned pixel x
//  pixel_y      out  COORD_W  unsigned pixel y
//  pix_last     out  1        current pixel is last of triangle (qualified by pix_valid)
//  busy         out  1        state != IDLE
//  done         out  1        one-cycle pulse after last pixel handshake
// BEHAVIOUR
//  Clock clk; reset rst is synchronous, active-high.
//  Reset: state IDLE; tri_ready=1 after reset released; pix_valid, pix_last, busy, done,
//   pixel_x/y, vtx_*_out = 0. Reset mid-scan aborts immediately: no done, no further pixels.
//  FSM: IDLE -> SETUP on tri_valid&tri_ready; SETUP -> SCAN (1 cycle); SCAN -> IDLE on
//   pix_valid&pix_ready&pix_last, done=1 in the following cycle; SETUP -> IDLE with done=1
//   if bbox empty (see clamp rules).
//  tri_ready = (state==IDLE) combinationally; vertices registered at accept.
//  SETUP: xmin/xmax = signed min/max of v*_x, ymin/ymax likewise; then clamp (below).
//  Latency: accept at cycle N -> first pix_valid=1 at N+2 with (xmin,ymin).
//  SCAN: pix_valid=1 continuously; outputs held unchanged while pix_valid&!pix_ready.
//   On handshake: if x<xmax then x+1; else x<=xmin, y+1. pix_last=1 when x==xmax&&y==ymax.
//  Degenerate bbox (1x1, single row, single column) legal; 1x1 gives one pixel with pix_last=1.
//  tri_valid while busy is ignored (tri_ready=0); command waits upstream.
//  Arithmetic: comparisons signed COORD_W; pixel counters unsigned COORD_W, no wrap possible
//   since bounds clamped to H_RES-1/V_RES-1.
// CONFIGURATION
//  RASTER_BBOX_CLAMP_EN defined: xmin=max(xmin,0), xmax=min(xmax,H_RES-1), same for y with
//   V_RES; if after clamping xmin>xmax or ymin>ymax the bbox is empty -> no pixels, done pulse.
//  Not defined: no clamping; any triangle with a bbox coordinate <0 or >=H_RES/V_RES is rejected
//   as empty (no pixels, done pulse); in-screen triangles scan identically in both builds.
// TESTING
//  T1 v=(2,1),(4,1),(2,3), pix_ready=1 -> 9 pixels (2,1)(3,1)(4,1)(2,2)..(4,3), pix_last on
//     (4,3), first pix_valid 2 cycles after accept, done 1 cycle after last.
//  T2 same triangle, pix_ready toggling 1/0 each cycle -> same 9-pixel sequence, outputs
//     stable during every stall, no drop/duplicate.
//  T3 v=(5,5),(5,5),(5,5) -> exactly one pixel (5,5) with pix_last=1, then done.
//  T4 v=(-3,-2),(1,-2),(1,1): CLAMP_EN -> pixels x0..1,y0..1 (4 pixels); without -> 0 pixels,
//     done pulse 2 cycles after accept.
//  T5 v=(700,10),(710,10),(705,20), H_RES=640: CLAMP_EN and not -> 0 pixels, done pulse.
//  T6 assert rst during pixel 5 of T1 -> next cycle pix_valid=0, busy=0, no done; new triangle
//     afterwards scans from its (xmin,ymin).

Source files
------------

// File: rtl/raster_bbox_scanner.sv
// Triangle bounding-box scanner: computes a vertex bbox and streams its pixels row-major.
// Optional macro RASTER_BBOX_CLAMP_EN clips the bbox to the screen instead of rejecting it.
module raster_bbox_scanner #(
  parameter int COORD_W = 11,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tri_valid,
  output logic                            tri_ready,
  input  logic signed [COORD_W-1:0]       v0_x,
  input  logic signed [COORD_W-1:0]       v0_y,
  input  logic signed [COORD_W-1:0]       v1_x,
  input  logic signed [COORD_W-1:0]       v1_y,
  input  logic signed [COORD_W-1:0]       v2_x,
  input  logic signed [COORD_W-1:0]       v2_y,
  output logic        [2:0][COORD_W-1:0]  vtx_x_out,
  output logic        [2:0][COORD_W-1:0]  vtx_y_out,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic        [COORD_W-1:0]       pixel_x,
  output logic        [COORD_W-1:0]       pixel_y,
  output logic                            pix_last,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_e;

  localparam logic signed [COORD_W-1:0] HMAX = COORD_W'(H_RES - 1);
  localparam logic signed [COORD_W-1:0] VMAX = COORD_W'(V_RES - 1);

  state_e state_q, state_d;
  logic [2:0][COORD_W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic done_q, done_d;

  logic signed [COORD_W-1:0] bx_lo, bx_hi, by_lo, by_hi;
  logic signed [COORD_W-1:0] cx_lo, cx_hi, cy_lo, cy_hi;
  logic empty;

  function automatic logic signed [COORD_W-1:0] smin3(input logic signed [COORD_W-1:0] a,
                                                        input logic signed [COORD_W-1:0] b,
                                                        input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [COORD_W-1:0] smax3(input logic signed [COORD_W-1:0] a,
                                                        input logic signed [COORD_W-1:0] b,
                                                        input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Bbox is derived from the registered vertices during SETUP.
  always_comb begin
    bx_lo = smin3($signed(vx_q[0]), $signed(vx_q[1]), $signed(vx_q[2]));
    bx_hi = smax3($signed(vx_q[0]), $signed(vx_q[1]), $signed(vx_q[2]));
    by_lo = smin3($signed(vy_q[0]), $signed(vy_q[1]), $signed(vy_q[2]));
    by_hi = smax3($signed(vy_q[0]), $signed(vy_q[1]), $signed(vy_q[2]));
`ifdef RASTER_BBOX_CLAMP_EN
    cx_lo = (bx_lo < 0)    ? '0   : bx_lo;
    cx_hi = (bx_hi > HMAX) ? HMAX : bx_hi;
    cy_lo = (by_lo < 0)    ? '0   : by_lo;
    cy_hi = (by_hi > VMAX) ? VMAX : by_hi;
    empty = (cx_lo > cx_hi) || (cy_lo > cy_hi);
`else
    cx_lo = bx_lo;
    cx_hi = bx_hi;
    cy_lo = by_lo;
    cy_hi = by_hi;
    empty = (bx_lo < 0) || (by_lo < 0) || (bx_hi > HMAX) || (by_hi > VMAX);
`endif
  end

  assign tri_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign pix_valid = (state_q == SCAN);
  assign pix_last  = pix_valid && (x_q == xmax_q) && (y_q == ymax_q);
  assign pixel_x   = x_q;
  assign pixel_y   = y_q;
  assign vtx_x_out = vx_q;
  assign vtx_y_out = vy_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    vx_d    = vx_q;
    vy_d    = vy_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (tri_valid) begin
          state_d = SETUP;
          vx_d    = {v2_x, v1_x, v0_x};
          vy_d    = {v2_y, v1_y, v0_y};
        end
      end
      SETUP: begin
        xmin_d = cx_lo;
        xmax_d = cx_hi;
        ymin_d = cy_lo;
        ymax_d = cy_hi;
        x_d    = cx_lo;
        y_d    = cy_lo;
        if (empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (pix_ready) begin
          if (pix_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (x_q < xmax_q) begin
            x_d = x_q + COORD_W'(1);
          end else begin
            x_d = xmin_q;
            y_d = y_q + COORD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_raster_bbox_scanner.sv
// Scoreboard bench for raster_bbox_scanner: stimulus queues expected pixels, a monitor pops them.
module tb_raster_bbox_scanner;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tri_valid = 1'b0;
  logic tri_ready;
  logic signed [CW-1:0] v0_x = '0, v0_y = '0, v1_x = '0, v1_y = '0, v2_x = '0, v2_y = '0;
  logic [2:0][CW-1:0] vtx_x_out, vtx_y_out;
  logic pix_valid;
  logic pix_ready = 1'b1;
  logic [CW-1:0] pixel_x, pixel_y;
  logic pix_last, busy, done;

  raster_bbox_scanner #(.COORD_W(CW), .H_RES(640), .V_RES(480)) dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .vtx_x_out(vtx_x_out), .vtx_y_out(vtx_y_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pix_last(pix_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; bit last; } pix_t;
  pix_t expq[$];

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int done_due = -10, first_due = -10, hs_cnt = 0;
  bit toggle = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern changes just after the edge so the monitor sees a stable value.
  always @(posedge clk) begin
    #1;
    if (toggle) pix_ready = ~pix_ready;
    else        pix_ready = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) begin
        if (first_due >= 0) begin
          chk("first_pixel_latency", cyc, first_due);
          first_due = -10;
        end
        if (expq.size() == 0) begin
          fail("unexpected_pixel");
        end else begin
          chk("pixel_x", int'(pixel_x), expq[0].x);
          chk("pixel_y", int'(pixel_y), expq[0].y);
          chk("pix_last", int'(pix_last), int'(expq[0].last));
          if (pix_ready) begin
            if (expq[0].last) done_due = cyc + 1;
            void'(expq.pop_front());
            hs_cnt++;
          end
        end
      end
      if (done || cyc == done_due) chk("done_pulse", int'(done), int'(cyc == done_due));
    end
  end

  task automatic push_box(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        pix_t p;
        p.x = x; p.y = y; p.last = (x == x1) && (y == y1);
        expq.push_back(p);
      end
  endtask

  task automatic send(input int ax, input int ay, input int bx, input int by,
                      input int cx, input int cy, input bit empty);
    @(negedge clk);
    chk("tri_ready_idle", int'(tri_ready), 1);
    v0_x = CW'(ax); v0_y = CW'(ay); v1_x = CW'(bx); v1_y = CW'(by);
    v2_x = CW'(cx); v2_y = CW'(cy);
    tri_valid = 1'b1;
    hs_cnt = 0;
    if (empty) done_due = cyc + 2;
    else       first_due = cyc + 2;
    @(negedge clk);
    chk("tri_ready_busy", int'(tri_ready), 0);
    chk("busy_setup", int'(busy), 1);
    tri_valid = 1'b0;
    v0_x = '0; v0_y = '0; v1_x = '0; v1_y = '0; v2_x = '0; v2_y = '0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && expq.size() == 0 && cyc > done_due) return;
    end
    fail({name, "_timeout"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pixel_x", int'(pixel_x), 0);
    chk("rst_vtx_x0", int'(vtx_x_out[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tri_ready", int'(tri_ready), 1);

    // T1: 3x3 bbox, always ready
    push_box(2, 4, 1, 3);
    send(2, 1, 4, 1, 2, 3, 1'b0);
    wait_idle("T1");
    chk("T1_count", hs_cnt, 9);
    chk("T1_vtx_x1", int'(vtx_x_out[1]), 4);
    chk("T1_vtx_y2", int'(vtx_y_out[2]), 3);
    chk("T1_vtx_x2", int'(vtx_x_out[2]), 2);

    // T2: same triangle with a stalling consumer
    toggle = 1'b1;
    push_box(2, 4, 1, 3);
    send(2, 1, 4, 1, 2, 3, 1'b0);
    wait_idle("T2");
    chk("T2_count", hs_cnt, 9);
    toggle = 1'b0;
    repeat (2) @(negedge clk);

    // T3: single pixel
    push_box(5, 5, 5, 5);
    send(5, 5, 5, 5, 5, 5, 1'b0);
    wait_idle("T3");
    chk("T3_count", hs_cnt, 1);

    // T4: partly off-screen at the origin
`ifdef RASTER_BBOX_CLAMP_EN
    push_box(0, 1, 0, 1);
    send(-3, -2, 1, -2, 1, 1, 1'b0);
    wait_idle("T4");
    chk("T4_count", hs_cnt, 4);
`else
    send(-3, -2, 1, -2, 1, 1, 1'b1);
    wait_idle("T4");
    chk("T4_count", hs_cnt, 0);
`endif
    chk("T4_vtx_x0", int'($signed(vtx_x_out[0])), -3);
    chk("T4_vtx_y1", int'($signed(vtx_y_out[1])), -2);

    // T5: entirely right of the screen
    send(700, 10, 710, 10, 705, 20, 1'b1);
    wait_idle("T5");
    chk("T5_count", hs_cnt, 0);

    // T6: reset while the fifth pixel of T1 is presented
    push_box(2, 4, 1, 3);
    send(2, 1, 4, 1, 2, 3, 1'b0);
    for (int i = 0; i < 50 && hs_cnt < 4; i++) @(negedge clk);
    chk("T6_pre_reset_count", hs_cnt, 4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    chk("T6_pix_valid", int'(pix_valid), 0);
    chk("T6_busy", int'(busy), 0);
    chk("T6_done", int'(done), 0);
    chk("T6_pixel_y", int'(pixel_y), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    push_box(7, 8, 3, 4);
    send(7, 3, 8, 3, 7, 4, 1'b0);
    wait_idle("T6b");
    chk("T6b_count", hs_cnt, 4);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
